// File: rtl/md_pkg.sv
// md_pkg: shared constants for the multiply/divide sequencer.
//   - md_op_t and the MD_* op codes driven by E-stage decode
//   - FSM state encoding (ST_IDLE / ST_RUN)
//   - default busy-cycle counts and counter width
package md_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_NONE  = 3'd0;
  localparam md_op_t MD_MULT  = 3'd1;
  localparam md_op_t MD_MULTU = 3'd2;
  localparam md_op_t MD_DIV   = 3'd3;
  localparam md_op_t MD_DIVU  = 3'd4;
  localparam md_op_t MD_MTHI  = 3'd5;
  localparam md_op_t MD_MTLO  = 3'd6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W           = 4;

  // True for the ops that occupy the sequencer for several cycles.
  function automatic logic md_is_long(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath.
// Ports:
//   op       in  3   captured operation code
//   a, b     in  32  captured rs / rt operands
//   result   out 64  {hi, lo}
//   div_zero out 1   DIV/DIVU with b == 0 (result must not be committed)
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;

  // Divisor forced to 1 on zero so the dividers never see 0; result is discarded anyway.
  assign b_safe   = (b == 32'd0) ? 32'd1 : b;
  assign div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // SV signed / and % truncate toward zero; remainder takes the dividend's sign.
  assign sa  = a;
  assign sb  = b_safe;
  assign q_s = sa / sb;
  assign r_s = sa % sb;
  assign q_u = a / b_safe;
  assign r_u = a % b_safe;

  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {r_s, q_s};
      MD_DIVU:  result = {r_u, q_u};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer with architectural HI/LO.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   md_op_E    in  3  E-stage op code (md_pkg MD_*)
//   rs_E, rt_E in  32 forwarded operands
//   md_use_D   in  1  D-stage instruction touches HI/LO
//   busy       out 1  operation in flight (registered)
//   md_stall   out 1  combinational stall request to hazard unit
//   hi, lo     out 32 architectural HI/LO
// Build option: MD_DIVZERO_FAST_EN makes divide-by-zero finish in one busy cycle.
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [0:0]          state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  logic                busy_q, busy_d;

  logic                start;
  logic [MD_CNT_W-1:0] div_load;
  logic [63:0]         arith_res;
  logic                arith_div_zero;

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (arith_res),
    .div_zero (arith_div_zero)
  );

  assign start    = md_is_long(md_op_E) && (state_q == ST_IDLE);
  assign md_stall = md_use_D & (busy_q | start);
  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Divide latency, optionally shortened when the divisor is zero.
`ifdef MD_DIVZERO_FAST_EN
  assign div_load = (rt_E == 32'd0) ? MD_CNT_W'(1) : MD_CNT_W'(DIV_CYCLES);
`else
  assign div_load = MD_CNT_W'(DIV_CYCLES);
`endif

  // Next-state: capture on start, count down in RUN, commit when the count hits 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          op_d    = md_op_E;
          a_d     = rs_E;
          b_d     = rt_E;
          cnt_d   = ((md_op_E == MD_MULT) || (md_op_E == MD_MULTU)) ?
                    MD_CNT_W'(MULT_CYCLES) : div_load;
        end else if (md_op_E == MD_MTHI) begin
          hi_d = rs_E;
        end else if (md_op_E == MD_MTLO) begin
          lo_d = rs_E;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - MD_CNT_W'(1);
        // <= 1 also recovers from a stray zero count.
        if (cnt_q <= MD_CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (!arith_div_zero) begin
            hi_d = arith_res[63:32];
            lo_d = arith_res[31:0];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: scoreboard bench for md_ctrl. Stimulus pushes expected
// {hi, lo, busy length} per long op; the monitor pops on each busy fall.
module tb_md_ctrl;
  import md_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned len;
  } exp_t;

`ifdef MD_DIVZERO_FAST_EN
  localparam int unsigned DZ_LEN = 1;
`else
  localparam int unsigned DZ_LEN = 10;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  md_op_E;
  logic [31:0] rs_E;
  logic [31:0] rt_E;
  logic        md_use_D;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op_E  (md_op_E),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .md_use_D (md_use_D),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op_E = op;
    rs_E    = a;
    rt_E    = b;
    tick();
    md_op_E = MD_NONE;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int unsigned n);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.len = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", budget);
    end
  endtask

  // Monitor: measures each busy run and checks HI/LO at the cycle busy drops.
  initial begin
    int unsigned run_len = 0;
    logic prev_busy = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        run_len   = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy === 1'b1) begin
          run_len++;
        end else if (prev_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: hi=0x%08h lo=0x%08h with empty scoreboard", hi, lo);
          end else begin
            e = exp_q.pop_front();
            chk("commit_hi", hi, e.hi);
            chk("commit_lo", lo, e.lo);
            chk("busy_len", 32'(run_len), 32'(e.len));
          end
          run_len = 0;
        end
        prev_busy = (busy === 1'b1);
      end
    end
  end

  initial begin
    md_op_E  = MD_NONE;
    rs_E     = '0;
    rt_E     = '0;
    md_use_D = 1'b1;
    reset    = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", 32'(md_stall), 32'd0);
    reset = 1'b0;
    tick();

    // Op code 7 behaves as NONE.
    md_op_E = 3'd7;
    #1 chk("op7_stall", 32'(md_stall), 32'd0);
    tick();
    md_op_E = MD_NONE;
    chk("op7_busy", 32'(busy), 32'd0);

    // MULT -3 * 5 with md_use_D high: stall in start cycle plus 5 busy cycles.
    push(32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    md_op_E = MD_MULT;
    rs_E    = 32'hFFFF_FFFD;
    rt_E    = 32'd5;
    #1 chk("stall_start", 32'(md_stall), 32'd1);
    tick();
    md_op_E = MD_NONE;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("stall_k+%0d", i), 32'(md_stall), (i <= 5) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    md_use_D = 1'b0;

    // DIV -7/2 then DIVU 7/2 back-to-back; no stall with md_use_D low.
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    md_op_E = MD_DIV;
    rs_E    = 32'hFFFF_FFF9;
    rt_E    = 32'd2;
    #1 chk("nostall_start", 32'(md_stall), 32'd0);
    tick();
    md_op_E = MD_NONE;
    chk("nostall_busy", 32'(md_stall), 32'd0);
    wait_idle(20);
    push(32'd1, 32'd3, 10);
    issue(MD_DIVU, 32'd7, 32'd2);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_idle(20);

    // MTHI in IDLE: one edge, LO untouched, no busy.
    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'd3);
    chk("mthi_busy", 32'(busy), 32'd0);

    // MTLO while RUN is ignored; MULT 2*3 commits afterwards.
    push(32'd0, 32'd6, 5);
    issue(MD_MULT, 32'd2, 32'd3);
    issue(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
    chk("mtlo_run_lo", lo, 32'd3);
    wait_idle(20);
    tick();

    // Divide by zero leaves HI/LO alone.
    issue(MD_MTHI, 32'hAAAA_5555, 32'd0);
    issue(MD_MTLO, 32'hAAAA_5555, 32'd0);
    chk("dz_pre_hi", hi, 32'hAAAA_5555);
    chk("dz_pre_lo", lo, 32'hAAAA_5555);
    push(32'hAAAA_5555, 32'hAAAA_5555, DZ_LEN);
    issue(MD_DIV, 32'd9, 32'd0);
    wait_idle(20);
    tick();

    // Asynchronous reset in busy cycle 4 of a DIV: clears at once, no later commit.
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    #3 reset = 1'b0;
    repeat (15) tick();
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    repeat (2) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide sequencer for the five-stage pipeline. It accepts a MULT/MULTU/DIV/DIVU/MTHI/MTLO operation from the E stage, runs it for a fixed multi-cycle latency, and commits the result to the HI/LO registers. While an operation is in flight it raises a stall request so the hazard logic holds any D-stage instruction that touches HI/LO. It sits beside the ALU in E, and its `hi`/`lo` outputs feed the MFHI/MFLO result mux.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (legal range 1–15).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (legal range 1–15).

Ports:
- `clk` input 1: single clock; rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `md_op_E` input 3: operation code from E-stage decode (codes in `md_pkg`).
- `rs_E` input 32: forwarded rs value (dividend, multiplicand, or MTHI/MTLO source).
- `rt_E` input 32: forwarded rt value (divisor or multiplier).
- `md_use_D` input 1: D-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- `busy` output 1: an operation is in flight.
- `md_stall` output 1: stall request to the hazard unit.
- `hi` output 32: architectural HI register.
- `lo` output 32: architectural LO register.

## Operation
- Op codes: `MD_NONE`=0, `MD_MULT`=1, `MD_MULTU`=2, `MD_DIV`=3, `MD_DIVU`=4, `MD_MTHI`=5, `MD_MTLO`=6. Code 7 is treated as `MD_NONE`.
- Start condition: `start` = `md_op_E` ∈ {1..4} and state is IDLE.
- State machine:
  - IDLE → RUN on `start`. The rising edge captures `rs_E`/`rt_E` and the op into internal registers, and loads the 4-bit counter with MULT_CYCLES or DIV_CYCLES.
  - RUN: the counter decrements each cycle. When it is 1, the next edge does three things: commits the pending result to HI/LO, clears `busy`, and returns the FSM to IDLE.
- Arithmetic rules:
  - MULT: signed 32×32 → 64-bit product; HI = [63:32], LO = [31:0].
  - MULTU: unsigned 32×32 → 64-bit product; same split.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
- Divide by zero: HI and LO are left unchanged, and the full DIV_CYCLES latency still applies.
- MTHI/MTLO in IDLE: the addressed register takes `rs_E` on the next edge, `busy` stays 0, and the other register is untouched.
- Any op while RUN, including MTHI/MTLO, is ignored; `md_stall` guarantees this never happens architecturally.
- `md_stall` = `md_use_D` & (`busy` | `start`). It is combinational and holds D while E is starting an operation or one is in flight.
- `busy` = (state == RUN); it is registered.
- Reset, at any time including mid-operation: state IDLE, counter 0, `busy` 0, HI 0, LO 0, and the pending result is discarded.

## Timing
- Start op present in E during cycle k, sampled at edge k:
  - `busy` = 1 in cycles k+1 through k+N (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO take the new values at the edge ending cycle k+N.
  - `busy` = 0 in cycle k+N+1, and MFHI/MFLO see the new value in that cycle.
- MTHI/MTLO: one-edge latency, no busy cycles.
- A new start is accepted in cycle k+N+1, back-to-back with no idle gap.
- `md_stall` reacts in the same cycle as `md_use_D` and `start`, with no registered delay.

## Configuration
- `MD_DIVZERO_FAST_EN` defined: DIV/DIVU with `rt_E` == 0 completes in 1 busy cycle (counter loaded with 1), and HI/LO are unchanged.
- `MD_DIVZERO_FAST_EN` not defined: divide by zero occupies the full DIV_CYCLES, and HI/LO are unchanged.

## Structure
- `md_pkg` holds:
  - the `MD_*` op-code constants and the 3-bit op type;
  - the state encoding (IDLE/RUN);
  - the default cycle constants.
- Sub-module `md_arith`: purely combinational. It takes op, a, and b, and returns a 64-bit {hi, lo} result plus a `div_zero` flag. It is evaluated on the captured operands.
- `md_ctrl` owns the FSM, the counter, the operand/pending registers, and HI/LO.

## Test plan
- MULT: rs=0xFFFFFFFD, rt=5 → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; `busy` falls the same edge.
- DIV then DIVU:
  - DIV rs=0xFFFFFFF9 (−7), rt=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU rs=7, rt=2 back-to-back in the next cycle → LO=3, HI=1.
- MTHI rs=0x12345678 in IDLE → HI=0x12345678 after 1 edge, LO unchanged, `busy` stays 0. Then MTLO while RUN → ignored, LO unchanged.
- Stall:
  - MULT start in cycle k with `md_use_D`=1 → `md_stall`=1 in cycles k through k+5 and 0 in k+6.
  - With `md_use_D`=0 → `md_stall`=0 throughout.
- Reset mid-operation: DIV started, `reset` pulsed asynchronously in cycle 4 → `busy`, HI, and LO are 0 immediately, and no commit occurs later.
- Divide by zero: DIV rs=9, rt=0 with HI=LO=0xAAAA5555 → HI/LO unchanged. Busy lasts 10 cycles without `MD_DIVZERO_FAST_EN` and 1 cycle with it.
